wrr_arbiter: RTL and testbench
==============================

// Module: wrr_arbiter
// PURPOSE
//   Parametrised weighted round-robin arbiter with registered one-hot grant, per-port burst weights,
//   per-port lock (grant hold) and a run-time fixed-priority mode. Successor to the single-cycle
//   round-robin arbiter. Sits in front of shared resources (bus/memory ports) where clients issue
//   multi-beat transfers and must keep ownership for a programmable number of beats.
// PARAMETERS
//   NUM_PORTS  4  number of requesters (>=2)
//   WEIGHT_W   4  width of each per-port weight field; max burst = 2**WEIGHT_W-1 beats
//   ID_W (localparam) = $clog2(NUM_PORTS)
// PORTS
//   clk          in   1                   clock, rising edge
//   rst          in   1                   asynchronous, active-high reset
//   request      in   NUM_PORTS           per-port request; a beat = grant[i] & request[i] in a cycle
//   lock         in   NUM_PORTS           per-port hold: owner keeps grant while request[i]&lock[i]
//   weight       in   NUM_PORTS*WEIGHT_W  per-port max beats per tenure; field i = [i*WEIGHT_W +: WEIGHT_W]
//   mode         in   1                   0 = weighted round-robin, 1 = fixed priority (port 0 highest)
//   grant        out  NUM_PORTS           registered one-hot (or zero) grant
//   grant_id     out  ID_W                index of granted port; 0 when valid_grant=0
//   valid_grant  out  1                   |grant
//   beat_cnt     out  WEIGHT_W            beats consumed by current owner this tenure (saturating)
// BEHAVIOUR
//   State: grant_q (one-hot), owner id, ptr (RR search start), cnt, w_lat (latched weight of owner).
//   Reset (async, rst=1): grant=0, grant_id=0, valid_grant=0, beat_cnt=0, ptr=0, w_lat=0.
//     Outputs clear immediately on rst assertion, mid-burst included; first grant at first edge after release.
//   Every rising edge, next state from current inputs and state:
//   HOLD: owner i valid and request[i]=1 and (lock[i]=1 or cnt+1 < w_lat) -> keep grant i, cnt<=cnt+1
//     (saturate at 2**WEIGHT_W-1 under lock).
//   ARBITRATE otherwise:
//     mode=0: search ports ptr, ptr+1, ... ptr+N-1 (mod NUM_PORTS); first with request=1 wins.
//     mode=1: lowest-index port with request=1 wins; ptr not used.
//     Winner j: grant<=onehot(j), cnt<=0, w_lat<=max(weight[j],1) (weight 0 treated as 1),
//       ptr<=(j+1) mod NUM_PORTS (also updated in mode=1).
//     No requests: grant<=0, cnt<=0, ptr unchanged.
//   Weight is sampled only at win; changes during a tenure take effect at that port's next win.
//   Outgoing owner is searched last, so a sole requester is re-granted back-to-back with no bubble.
//   Mode change takes effect at the next ARBITRATE; an ongoing HOLD is not cut short.
//   Latency: request high before edge t -> grant visible after edge t (1 cycle). Request drop before
//     edge t -> grant moves/clears after edge t; grant[i] with request[i]=0 in that cycle is not a beat.
//   Invariants: $onehot0(grant); grant_id consistent with grant; valid_grant == |grant; beat_cnt==cnt.
//   Fairness (mode=0, lock=0): a port holding request continuously is granted within
//     sum of other ports' effective weights + 1 cycles. mode=1 gives no fairness guarantee.
// TESTING
//   1 Reset: rst=1, request=4'b1111 -> grant=0, beat_cnt=0; release -> after 1st edge grant=4'b0001, grant_id=0.
//   2 WRR: weights {3,1,2,1} for ports {3,2,1,0}, request=4'b1111 constant -> grant_id sequence
//     0,1,1,2,3,3,3,0,1,1,... ; beat_cnt 0,0,1,0,0,1,2,...
//   3 Early drop: port0 weight 4, ports 0,2 requesting; port0 drops after 2 beats -> grant_id=2 on the
//     next edge, port2 gets its full weight.
//   4 Lock: port1 weight 1, lock[1]=1 for 6 cycles, all requesting -> grant_id=1 for 6 cycles, beat_cnt
//     0..5; lock drops -> grant_id=2 next edge.
//   5 Fixed mode: mode=1, request=4'b1010, all weights 1 -> grant_id=1 every cycle; port3 never granted;
//     switch mode=0 -> grant_id=3 at next arbitration.
//   6 Corners: sole requester port3, weight 1 -> grant=4'b1000 every cycle, no bubble; weight 0 behaves as 1;
//     rst asserted mid-burst -> grant=0 immediately, post-release arbitration restarts from port 0.

Source files
------------

// File: rtl/wrr_arbiter.sv
// -----------------------------------------------------------------------------
// wrr_arbiter
//   Weighted round-robin arbiter with a registered one-hot grant. Each port is
//   allowed up to its programmed number of beats per tenure. A per-port lock
//   lets the current owner keep the grant for as long as it asserts it. A
//   run-time mode input switches arbitration to fixed priority, where port 0
//   has the highest priority.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   request      in   [NUM_PORTS]           per-port request
//   lock         in   [NUM_PORTS]           per-port grant hold
//   weight       in   [NUM_PORTS*WEIGHT_W]  per-port max beats per tenure,
//                                           field i = [i*WEIGHT_W +: WEIGHT_W]
//   mode         in   0 = weighted round-robin, 1 = fixed priority
//   grant        out  [NUM_PORTS] registered one-hot (or zero) grant
//   grant_id     out  [ID_W] index of the granted port, 0 when idle
//   valid_grant  out  |grant
//   beat_cnt     out  [WEIGHT_W] beats consumed by the owner this tenure
// -----------------------------------------------------------------------------
module wrr_arbiter #(
    parameter int  NUM_PORTS = 4,
    parameter int  WEIGHT_W  = 4,
    localparam int ID_W      = $clog2(NUM_PORTS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS-1:0]          request,
    input  logic [NUM_PORTS-1:0]          lock,
    input  logic [NUM_PORTS*WEIGHT_W-1:0] weight,
    input  logic                          mode,
    output logic [NUM_PORTS-1:0]          grant,
    output logic [ID_W-1:0]               grant_id,
    output logic                          valid_grant,
    output logic [WEIGHT_W-1:0]           beat_cnt
);

    logic [NUM_PORTS-1:0] grant_reg, grant_next;
    logic [ID_W-1:0]      owner_reg, owner_next;
    logic [ID_W-1:0]      ptr_reg, ptr_next;
    logic [WEIGHT_W-1:0]  cnt_reg, cnt_next;
    logic [WEIGHT_W-1:0]  w_lat_reg, w_lat_next;

    // Effective weight per port. A weight of 0 is treated as 1 so that a
    // winner always gets at least one beat.
    logic [WEIGHT_W-1:0] eff_weight [NUM_PORTS];

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_weight
            logic [WEIGHT_W-1:0] w_field;
            assign w_field        = weight[gi*WEIGHT_W +: WEIGHT_W];
            assign eff_weight[gi] = (w_field == '0) ? WEIGHT_W'(1) : w_field;
        end
    endgenerate

    // Incremented beat count, one bit wider so the comparison against the
    // latched weight and the saturation check both see the carry.
    logic [WEIGHT_W:0] cnt_inc;
    logic              owner_valid;
    logic              hold;

    assign cnt_inc     = {1'b0, cnt_reg} + 1'b1;
    assign owner_valid = |grant_reg;
    assign hold        = owner_valid && request[owner_reg] &&
                         (lock[owner_reg] || (cnt_inc < {1'b0, w_lat_reg}));

    // Winner search. In round-robin mode the search starts at ptr. ptr is
    // always set to one past the last winner, so the outgoing owner is
    // examined last. In fixed-priority mode the search starts at port 0.
    logic            found;
    logic [ID_W-1:0] win_id;
    logic [ID_W-1:0] idx_sel;

    always_comb begin
        found   = 1'b0;
        win_id  = '0;
        idx_sel = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (mode) begin
                idx_sel = ID_W'(k);
            end else begin
                idx_sel = ID_W'((int'(ptr_reg) + k) % NUM_PORTS);
            end
            if (!found && request[idx_sel]) begin
                found  = 1'b1;
                win_id = idx_sel;
            end
        end
    end

    always_comb begin
        grant_next = grant_reg;
        owner_next = owner_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        w_lat_next = w_lat_reg;

        if (hold) begin
            // A locked owner can exceed the field range, so the count
            // saturates instead of wrapping.
            cnt_next = cnt_inc[WEIGHT_W] ? cnt_reg : cnt_inc[WEIGHT_W-1:0];
        end else if (found) begin
            grant_next         = '0;
            grant_next[win_id] = 1'b1;
            owner_next         = win_id;
            cnt_next           = '0;
            w_lat_next         = eff_weight[win_id];
            ptr_next           = ID_W'((int'(win_id) + 1) % NUM_PORTS);
        end else begin
            grant_next = '0;
            owner_next = '0;
            cnt_next   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_reg <= '0;
            owner_reg <= '0;
            ptr_reg   <= '0;
            cnt_reg   <= '0;
            w_lat_reg <= '0;
        end else begin
            grant_reg <= grant_next;
            owner_reg <= owner_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
            w_lat_reg <= w_lat_next;
        end
    end

    assign grant       = grant_reg;
    assign grant_id    = owner_reg;
    assign valid_grant = owner_valid;
    assign beat_cnt    = cnt_reg;

endmodule

// File: tb/tb_wrr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wrr_arbiter
//   Directed self-checking bench for wrr_arbiter (NUM_PORTS=4, WEIGHT_W=4).
//   The expected grant sequences are computed by hand from the arbitration
//   rules.
// -----------------------------------------------------------------------------
module tb_wrr_arbiter;

    localparam int NP = 4;
    localparam int WW = 4;

    logic          clk;
    logic          rst;
    logic [NP-1:0] request;
    logic [NP-1:0] lock;
    logic [NP*WW-1:0] weight;
    logic          mode;
    logic [NP-1:0] grant;
    logic [1:0]    grant_id;
    logic          valid_grant;
    logic [WW-1:0] beat_cnt;

    int checks = 0;
    int errors = 0;

    wrr_arbiter #(.NUM_PORTS(NP), .WEIGHT_W(WW)) dut (
        .clk         (clk),
        .rst         (rst),
        .request     (request),
        .lock        (lock),
        .weight      (weight),
        .mode        (mode),
        .grant       (grant),
        .grant_id    (grant_id),
        .valid_grant (valid_grant),
        .beat_cnt    (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Checks all outputs against the expected owner, count and valid flag.
    // The expected grant vector is derived from the expected owner.
    task automatic check_state(input string tag, input int exp_id, input int exp_cnt,
                               input int exp_valid);
        int exp_grant;
        exp_grant = exp_valid ? (1 << exp_id) : 0;
        check_val({tag, ".grant"}, int'(grant), exp_grant);
        check_val({tag, ".id"}, int'(grant_id), exp_valid ? exp_id : 0);
        check_val({tag, ".valid"}, int'(valid_grant), exp_valid);
        check_val({tag, ".cnt"}, int'(beat_cnt), exp_cnt);
        $display("%-12s t=%0t req=%b lock=%b mode=%0d grant=%b id=%0d cnt=%0d",
                 tag, $time, request, lock, mode, grant, grant_id, beat_cnt);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [NP*WW-1:0] pack_w(input int w3, input int w2, input int w1,
                                                input int w0);
        return {WW'(w3), WW'(w2), WW'(w1), WW'(w0)};
    endfunction

    int exp_id2  [10] = '{0, 1, 1, 2, 3, 3, 3, 0, 1, 1};
    int exp_cnt2 [10] = '{0, 0, 1, 0, 0, 1, 2, 0, 0, 1};

    initial begin
        rst     = 1'b1;
        request = 4'b1111;
        lock    = 4'b0000;
        mode    = 1'b0;
        weight  = pack_w(3, 1, 2, 1);

        // 1: reset holds grant low despite requests.
        tick();
        tick();
        check_state("rst_hold", 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // 2: weighted round-robin sequence. The first entry is the first
        // grant after reset release.
        for (int i = 0; i < 10; i++) begin
            tick();
            check_state($sformatf("wrr[%0d]", i), exp_id2[i], exp_cnt2[i], 1);
        end

        // 3: early drop. Port0 has weight 4 and releases after 2 beats.
        weight  = pack_w(1, 3, 1, 4);
        request = 4'b0101;
        do_reset();
        tick(); check_state("drop0", 0, 0, 1);
        tick(); check_state("drop1", 0, 1, 1);
        request = 4'b0100;
        tick(); check_state("drop2", 2, 0, 1);
        tick(); check_state("drop3", 2, 1, 1);
        tick(); check_state("drop4", 2, 2, 1);
        tick(); check_state("drop5", 2, 0, 1);

        // 4: lock. Port1 has weight 1 and holds the grant for 6 cycles.
        weight  = pack_w(1, 1, 1, 1);
        request = 4'b1111;
        do_reset();
        tick(); check_state("lock_pre", 0, 0, 1);
        lock = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_state($sformatf("lock[%0d]", i), 1, i, 1);
        end
        lock = 4'b0000;
        tick(); check_state("lock_end", 2, 0, 1);

        // 5: fixed-priority mode. Port3 is starved while port1 requests.
        mode    = 1'b1;
        request = 4'b1010;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            check_state($sformatf("fix[%0d]", i), 1, 0, 1);
        end
        mode = 1'b0;
        tick(); check_state("fix_rr0", 3, 0, 1);
        tick(); check_state("fix_rr1", 1, 0, 1);

        // 6a: sole requester is re-granted every cycle with no bubble.
        request = 4'b1000;
        weight  = pack_w(1, 1, 1, 1);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            check_state($sformatf("sole[%0d]", i), 3, 0, 1);
        end

        // 6b: weight 0 behaves as weight 1.
        weight  = pack_w(0, 0, 0, 0);
        request = 4'b1001;
        do_reset();
        tick(); check_state("w0_a", 0, 0, 1);
        tick(); check_state("w0_b", 3, 0, 1);
        tick(); check_state("w0_c", 0, 0, 1);

        // 6c: beat count saturates under a long lock.
        weight  = pack_w(2, 1, 1, 1);
        request = 4'b1000;
        lock    = 4'b1000;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            tick();
            check_state($sformatf("sat[%0d]", i), 3, (i > 15) ? 15 : i, 1);
        end

        // 6d: reset asserted mid-burst clears the outputs at once, and
        // arbitration then restarts from port 0. Before the reset, ptr is 2.
        lock    = 4'b0000;
        request = 4'b0010;
        tick(); check_state("mid_pre", 1, 0, 1);
        #3;
        rst = 1'b1;
        #1;
        check_state("mid_rst", 0, 0, 0);
        @(negedge clk);
        rst     = 1'b0;
        request = 4'b1111;
        tick(); check_state("mid_post", 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
